// File: rtl/line_mem_if.sv
// rtl/line_mem_if.sv - cache-to-backing-store line request/response bus
interface line_mem_if;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_req_rw;
  logic         mem_req_valid;
  logic [127:0] mem_data;
  logic         mem_ready;
  logic         mem_valid;
  logic         busy;
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;

  modport master (
    output mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
    input  mem_data, mem_ready, mem_valid, busy, rd_count, wr_count
  );

  modport slave (
    input  mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid,
    output mem_data, mem_ready, mem_valid, busy, rd_count, wr_count
  );
endinterface

// File: rtl/line_mem_ctrl.sv
// rtl/line_mem_ctrl.sv - fixed-latency 128-bit line backing store with rd/wr counters
module line_mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int LINE_AW = 12,
  parameter int INIT_EN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  line_mem_if.slave  bus
);
  localparam int DEPTH = 1 << LINE_AW;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [LINE_AW-1:0]   idx_q, idx_d;
  logic [127:0]         data_q, data_d;
  logic                 rw_q, rw_d;
  logic [127:0]         mem_data_q, mem_data_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic [31:0]          rd_cnt_q, rd_cnt_d;
  logic [31:0]          wr_cnt_q, wr_cnt_d;
  logic                 commit_wr;
  logic [127:0]         line_rd [DEPTH];
  logic                 unused_addr;

  assign unused_addr = ^{bus.mem_req_addr[31:4+LINE_AW], bus.mem_req_addr[3:0]};

  // Line storage sits outside reset so contents survive an aborted transaction.
  for (genvar g = 0; g < DEPTH; g++) begin : g_line
    logic [127:0] line_q = (INIT_EN != 0) ? {4{32'(g)}} : {128{1'bx}};

    always_ff @(posedge clk) begin
      if (commit_wr && idx_q == LINE_AW'(g)) begin
        line_q <= data_q;
      end
    end

    assign line_rd[g] = line_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    data_d     = data_q;
    rw_d       = rw_q;
    mem_data_d = mem_data_q;
    ready_d    = 1'b0;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    commit_wr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_req_valid) begin
          idx_d   = bus.mem_req_addr[4 +: LINE_AW];
          data_d  = bus.mem_req_data;
          rw_d    = bus.mem_req_rw;
          cnt_d   = 8'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          ready_d = 1'b1;
          valid_d = ~rw_q;
          if (rw_q) begin
            commit_wr = 1'b1;
          end else begin
            mem_data_d = line_rd[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (rw_q) begin
          wr_cnt_d = wr_cnt_q + 32'd1;
        end else begin
          rd_cnt_d = rd_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      idx_q      <= '0;
      data_q     <= '0;
      rw_q       <= 1'b0;
      mem_data_q <= '0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      rd_cnt_q   <= 32'd0;
      wr_cnt_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      rw_q       <= rw_d;
      mem_data_q <= mem_data_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign bus.mem_data  = mem_data_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.rd_count  = rd_cnt_q;
  assign bus.wr_count  = wr_cnt_q;
endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb/tb_line_mem_ctrl.sv - scoreboard bench for line_mem_ctrl at LATENCY 4 and 1
module tb_line_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_mem_if if4 ();
  line_mem_if if1 ();

  line_mem_ctrl #(.LATENCY(4), .LINE_AW(12), .INIT_EN(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave)
  );
  line_mem_ctrl #(.LATENCY(1), .LINE_AW(12), .INIT_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );

  typedef struct {
    bit           rw;
    logic [127:0] data;
    int           exp_cyc;
  } exp_t;

  exp_t         sbq[$];
  logic [127:0] model_mem [int];
  int           model_rd = 0;
  int           model_wr = 0;
  logic [127:0] last_rd = '0;

  function automatic logic [127:0] ref_line(input int idx);
    logic [31:0] i32;
    i32 = idx;
    if (model_mem.exists(idx)) return model_mem[idx];
    return {4{i32}};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if4.mem_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready at cycle %0d: got ready=1 expected 0", cyc);
      end else begin
        e = sbq.pop_front();
        check("ready_cycle", cyc, e.exp_cyc);
        check("mem_valid", if4.mem_valid, !e.rw);
        check("mem_data", if4.mem_data, e.data);
      end
    end
  end

  // b2b: called in the ready cycle, so the accept lands one IDLE cycle later.
  task automatic issue(input logic [31:0] addr, input logic [127:0] data, input bit rw, input bit b2b);
    int   idx;
    exp_t e;
    idx = int'(addr[15:4]);
    if4.mem_req_addr  = addr;
    if4.mem_req_data  = data;
    if4.mem_req_rw    = rw;
    if4.mem_req_valid = 1'b1;
    e.rw      = rw;
    e.exp_cyc = (b2b ? cyc + 2 : cyc + 1) + 4;
    if (rw) begin
      model_mem[idx] = data;
      model_wr++;
    end else begin
      last_rd = ref_line(idx);
      model_rd++;
    end
    e.data = last_rd;
    sbq.push_back(e);
  endtask

  task automatic wait_ready();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if4.mem_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
    end
  endtask

  task automatic txn(input logic [31:0] addr, input logic [127:0] data, input bit rw);
    issue(addr, data, rw, 1'b0);
    wait_ready();
    if4.mem_req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_counts();
    check("rd_count", if4.rd_count, model_rd);
    check("wr_count", if4.wr_count, model_wr);
  endtask

  task automatic lat1_read(input logic [11:0] idx);
    int           c0;
    int           busy_n;
    int           ready_cyc;
    logic [127:0] rdata;
    logic [31:0]  i32;
    logic         rvalid;
    busy_n    = 0;
    ready_cyc = -1;
    rdata     = '0;
    rvalid    = 1'b0;
    i32       = {20'd0, idx};
    c0 = cyc;
    if1.mem_req_addr  = {16'h0, idx, 4'h0};
    if1.mem_req_rw    = 1'b0;
    if1.mem_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if1.busy) busy_n++;
      if (if1.mem_ready && ready_cyc < 0) begin
        ready_cyc = cyc;
        rdata     = if1.mem_data;
        rvalid    = if1.mem_valid;
        if1.mem_req_valid = 1'b0;
      end
    end
    check("lat1_ready_cycle", ready_cyc, c0 + 2);
    check("lat1_busy_cycles", busy_n, 2);
    check("lat1_mem_valid", rvalid, 1'b1);
    check("lat1_mem_data", rdata, {4{i32}});
  endtask

  initial begin
    bit           at_ready;
    bit           rw;
    bit           b2b;
    int           idx;
    logic [31:0]  addr;
    logic [127:0] data;

    if4.mem_req_addr = '0; if4.mem_req_data = '0; if4.mem_req_rw = 1'b0; if4.mem_req_valid = 1'b0;
    if1.mem_req_addr = '0; if1.mem_req_data = '0; if1.mem_req_rw = 1'b0; if1.mem_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_data", if4.mem_data, '0);
    check("rst_mem_ready", if4.mem_ready, 1'b0);
    check("rst_mem_valid", if4.mem_valid, 1'b0);
    check("rst_busy", if4.busy, 1'b0);
    check_counts();
    rst_n = 1'b1;
    @(negedge clk);

    txn(32'h0000_0050, '0, 1'b0);
    check_counts();

    txn(32'h0000_0120, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 1'b1);
    txn(32'h0000_012C, '0, 1'b0);
    check_counts();

    txn(32'h0001_0010, {16{8'hA5}}, 1'b1);
    txn(32'h0000_0010, '0, 1'b0);

    issue(32'h0000_0070, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1, 1'b0);
    wait_ready();
    issue(32'h0000_0090, '0, 1'b0, 1'b1);
    wait_ready();
    if4.mem_req_valid = 1'b0;
    @(negedge clk);
    check("b2b_mem_data", if4.mem_data, {4{32'h9}});
    check_counts();

    // Abort a write two cycles into BUSY; nothing may be committed or counted.
    if4.mem_req_addr  = 32'h0000_0030;
    if4.mem_req_data  = {128{1'b1}};
    if4.mem_req_rw    = 1'b1;
    if4.mem_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    if4.mem_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_rd = 0;
    model_wr = 0;
    last_rd  = '0;
    @(negedge clk);
    check_counts();
    txn(32'h0000_0030, '0, 1'b0);
    check("abort_line3", last_rd, {4{32'h3}});
    check_counts();

    at_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      idx  = int'($urandom_range(0, 7)) + (($urandom_range(0, 3) == 0) ? 4088 : 0);
      addr = ($urandom() & 32'hFFFF_000F) | (32'(idx) << 4);
      data = {$urandom(), $urandom(), $urandom(), $urandom()};
      rw   = 1'($urandom_range(0, 1));
      b2b  = 1'($urandom_range(0, 1));
      if (at_ready && !b2b) begin
        if4.mem_req_valid = 1'b0;
        @(negedge clk);
        at_ready = 1'b0;
      end
      issue(addr, data, rw, at_ready);
      wait_ready();
      at_ready = 1'b1;
    end
    if4.mem_req_valid = 1'b0;
    @(negedge clk);
    check_counts();
    check("scoreboard_empty", sbq.size(), 0);

    lat1_read(12'd0);
    lat1_read(12'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
